hazard_scheduler: RTL and testbench

- Stall/forward scheduler for the 5-stage (F/D/E/M/W) MIPS pipeline.
- Consumes the per-instruction T_use/T_new/destination info produced by the D-stage decoder.
- Keeps its own scoreboard of in-flight destination registers and their remaining T_new for E, M and W.
- Each cycle it emits stall/bubble control and operand-forwarding selects for D, E and M consumers, and counts stall cycles.

---
 rtl/hazard_scheduler_pkg.sv | 35 +++
 rtl/hazard_scheduler_fwd_select.sv | 32 +++
 rtl/hazard_scheduler.sv | 126 ++++++++++++
 tb/tb_hazard_scheduler.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/hazard_scheduler_pkg.sv
// Shared types and constants for the MIPS stall/forward scheduler.
package hazard_scheduler_pkg;

  localparam int unsigned GPR_W  = 5;
  localparam int unsigned TNEW_W = 2;
  localparam int unsigned SEL_W  = 2;

  // T_use value meaning "operand never read"
  localparam logic [1:0] T_USE_NONE = 2'd3;

  // Forwarding select encodings
  localparam logic [SEL_W-1:0] FWD_GRF = 2'd0;
  localparam logic [SEL_W-1:0] FWD_E   = 2'd1;
  localparam logic [SEL_W-1:0] FWD_M   = 2'd2;
  localparam logic [SEL_W-1:0] FWD_W   = 2'd3;

  // T_new on entering E
  localparam logic [TNEW_W-1:0] TNEW_ALU  = 2'd1;
  localparam logic [TNEW_W-1:0] TNEW_LOAD = 2'd2;
  localparam logic [TNEW_W-1:0] TNEW_LINK = 2'd0;

  // Per-stage scoreboard entry
  typedef struct packed {
    logic [GPR_W-1:0]  wa;
    logic [TNEW_W-1:0] tnew;
    logic [GPR_W-1:0]  rs;
    logic [GPR_W-1:0]  rt;
  } stage_t;

  // One pipeline step closer to producing the result, floor at zero
  function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - TNEW_W'(1);
  endfunction

endpackage

// File: rtl/hazard_scheduler_fwd_select.sv
// Priority picker: nearest stage holding a ready value for addr wins.
module fwd_select
  import hazard_scheduler_pkg::*;
(
  input  logic [GPR_W-1:0]  addr,
  input  logic              e_en,
  input  logic [GPR_W-1:0]  e_wa,
  input  logic [TNEW_W-1:0] e_tnew,
  input  logic              m_en,
  input  logic [GPR_W-1:0]  m_wa,
  input  logic [TNEW_W-1:0] m_tnew,
  input  logic              w_en,
  input  logic [GPR_W-1:0]  w_wa,
  input  logic [TNEW_W-1:0] w_tnew,
  output logic [SEL_W-1:0]  sel
);

  function automatic logic hit(input logic en, input logic [GPR_W-1:0] wa,
                               input logic [TNEW_W-1:0] tnew,
                               input logic [GPR_W-1:0] a);
    return en && (wa == a) && (wa != '0) && (tnew == '0);
  endfunction

  // E over M over W, GRF when nothing is ready
  always_comb begin
    sel = FWD_GRF;
    if (hit(e_en, e_wa, e_tnew, addr))      sel = FWD_E;
    else if (hit(m_en, m_wa, m_tnew, addr)) sel = FWD_M;
    else if (hit(w_en, w_wa, w_tnew, addr)) sel = FWD_W;
  end

endmodule

// File: rtl/hazard_scheduler.sv
// Stall/forward scheduler for the 5-stage F/D/E/M/W MIPS pipeline.
module hazard_scheduler
  import hazard_scheduler_pkg::*;
#(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned REG_W = GPR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] d_rs,
  input  logic [REG_W-1:0] d_rt,
  input  logic [1:0]       d_tuse_rs,
  input  logic [1:0]       d_tuse_rt,
  input  logic [REG_W-1:0] d_wa,
  input  logic [1:0]       d_tnew,
  output logic             stall,
  output logic             flush_e,
  output logic [1:0]       fwd_d_rs,
  output logic [1:0]       fwd_d_rt,
  output logic [1:0]       fwd_e_rs,
  output logic [1:0]       fwd_e_rt,
  output logic [1:0]       fwd_m_rt,
  output logic [CNT_W-1:0] stall_cnt
);

  stage_t            e_q;
  logic [GPR_W-1:0]  m_wa;
  logic [TNEW_W-1:0] m_tnew;
  logic [GPR_W-1:0]  m_rt;
  logic [GPR_W-1:0]  w_wa;
  logic [TNEW_W-1:0] w_tnew;

  logic [GPR_W-1:0]  rs_a;
  logic [GPR_W-1:0]  rt_a;
  logic              stall_rs;
  logic              stall_rt;

  assign rs_a = GPR_W'(d_rs);
  assign rt_a = GPR_W'(d_rt);

  // A source stalls when a producer in E or M cannot deliver by its use cycle
  function automatic logic src_stall(input logic [GPR_W-1:0] a,
                                     input logic [1:0] tuse,
                                     input logic [GPR_W-1:0] ewa,
                                     input logic [TNEW_W-1:0] etn,
                                     input logic [GPR_W-1:0] mwa,
                                     input logic [TNEW_W-1:0] mtn);
    return (a != '0) && (tuse != T_USE_NONE) &&
           (((a == ewa) && (etn > tuse)) || ((a == mwa) && (mtn > tuse)));
  endfunction

  // Combinational stall decision from D inputs and current scoreboard
  always_comb begin
    stall_rs = src_stall(rs_a, d_tuse_rs, e_q.wa, e_q.tnew, m_wa, m_tnew);
    stall_rt = src_stall(rt_a, d_tuse_rt, e_q.wa, e_q.tnew, m_wa, m_tnew);
  end

  assign stall   = stall_rs | stall_rt;
  assign flush_e = stall;

  fwd_select u_fwd_d_rs (
    .addr(rs_a),
    .e_en(1'b1), .e_wa(e_q.wa), .e_tnew(e_q.tnew),
    .m_en(1'b1), .m_wa(m_wa),   .m_tnew(m_tnew),
    .w_en(1'b1), .w_wa(w_wa),   .w_tnew(w_tnew),
    .sel(fwd_d_rs)
  );

  fwd_select u_fwd_d_rt (
    .addr(rt_a),
    .e_en(1'b1), .e_wa(e_q.wa), .e_tnew(e_q.tnew),
    .m_en(1'b1), .m_wa(m_wa),   .m_tnew(m_tnew),
    .w_en(1'b1), .w_wa(w_wa),   .w_tnew(w_tnew),
    .sel(fwd_d_rt)
  );

  fwd_select u_fwd_e_rs (
    .addr(e_q.rs),
    .e_en(1'b0), .e_wa(e_q.wa), .e_tnew(e_q.tnew),
    .m_en(1'b1), .m_wa(m_wa),   .m_tnew(m_tnew),
    .w_en(1'b1), .w_wa(w_wa),   .w_tnew(w_tnew),
    .sel(fwd_e_rs)
  );

  fwd_select u_fwd_e_rt (
    .addr(e_q.rt),
    .e_en(1'b0), .e_wa(e_q.wa), .e_tnew(e_q.tnew),
    .m_en(1'b1), .m_wa(m_wa),   .m_tnew(m_tnew),
    .w_en(1'b1), .w_wa(w_wa),   .w_tnew(w_tnew),
    .sel(fwd_e_rt)
  );

  fwd_select u_fwd_m_rt (
    .addr(m_rt),
    .e_en(1'b0), .e_wa(e_q.wa), .e_tnew(e_q.tnew),
    .m_en(1'b0), .m_wa(m_wa),   .m_tnew(m_tnew),
    .w_en(1'b1), .w_wa(w_wa),   .w_tnew(w_tnew),
    .sel(fwd_m_rt)
  );

  // Scoreboard advance, bubble insertion on stall, saturating stall counter
  always_ff @(posedge clk) begin
    if (reset) begin
      e_q       <= '0;
      m_wa      <= '0;
      m_tnew    <= '0;
      m_rt      <= '0;
      w_wa      <= '0;
      w_tnew    <= '0;
      stall_cnt <= '0;
    end else begin
      m_wa   <= e_q.wa;
      m_tnew <= tnew_dec(e_q.tnew);
      m_rt   <= e_q.rt;
      w_wa   <= m_wa;
      w_tnew <= tnew_dec(m_tnew);
      if (stall) begin
        e_q <= '0;
        if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      end else begin
        e_q <= '{wa: GPR_W'(d_wa), tnew: d_tnew, rs: rs_a, rt: rt_a};
      end
    end
  end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Self-checking bench for hazard_scheduler: table of D-stage vectors + scoreboard.
module tb_hazard_scheduler;
  import hazard_scheduler_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  d_rs, d_rt, d_wa;
  logic [1:0]  d_tuse_rs, d_tuse_rt, d_tnew;
  logic        stall, flush_e;
  logic [1:0]  fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt;
  logic [31:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  rs, rt;
    logic [1:0]  tur, tut;
    logic [4:0]  wa;
    logic [1:0]  tn;
    logic        st;
    logic [1:0]  fdrs, fdrt, fers, fert, fmrt;
    logic [31:0] cnt;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs[NV];
  vec_t sb[$];

  hazard_scheduler #(.CNT_W(32), .REG_W(5)) dut (
    .clk(clk), .reset(reset),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_wa(d_wa), .d_tnew(d_tnew),
    .stall(stall), .flush_e(flush_e),
    .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt),
    .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt), .fwd_m_rt(fwd_m_rt),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic vec_t v(input int rs, input int rt, input int tur, input int tut,
                             input int wa, input int tn, input int st,
                             input int fdrs, input int fdrt, input int fers,
                             input int fert, input int fmrt, input int cnt);
    vec_t r;
    r.rs = 5'(rs);   r.rt = 5'(rt);   r.tur = 2'(tur); r.tut = 2'(tut);
    r.wa = 5'(wa);   r.tn = 2'(tn);   r.st = 1'(st);
    r.fdrs = 2'(fdrs); r.fdrt = 2'(fdrt); r.fers = 2'(fers);
    r.fert = 2'(fert); r.fmrt = 2'(fmrt); r.cnt = 32'(cnt);
    return r;
  endfunction

  function automatic vec_t nop(input int fers, input int fert, input int fmrt, input int cnt);
    return v(0, 0, 3, 3, 0, 0, 0, 0, 0, fers, fert, fmrt, cnt);
  endfunction

  task automatic chk(input string name, input int tag, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step=%0d got=%0d want=%0d", name, tag, act, exp);
    end
  endtask

  // Drive one D-stage instruction, queue its expectation, compare at negedge
  task automatic apply(input vec_t vi, input logic rst, input int tag);
    vec_t e;
    @(posedge clk); #1;
    reset = rst;
    d_rs = vi.rs; d_rt = vi.rt; d_tuse_rs = vi.tur; d_tuse_rt = vi.tut;
    d_wa = vi.wa; d_tnew = vi.tn;
    sb.push_back(vi);
    @(negedge clk);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", tag, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("stall",     tag, 32'(stall),     32'(e.st));
      chk("flush_e",   tag, 32'(flush_e),   32'(e.st));
      chk("fwd_d_rs",  tag, 32'(fwd_d_rs),  32'(e.fdrs));
      chk("fwd_d_rt",  tag, 32'(fwd_d_rt),  32'(e.fdrt));
      chk("fwd_e_rs",  tag, 32'(fwd_e_rs),  32'(e.fers));
      chk("fwd_e_rt",  tag, 32'(fwd_e_rt),  32'(e.fert));
      chk("fwd_m_rt",  tag, 32'(fwd_m_rt),  32'(e.fmrt));
      chk("stall_cnt", tag, stall_cnt,      e.cnt);
    end
  endtask

  // W entry must never hold a pending result
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      checks++;
      if (dut.w_tnew !== 2'd0) begin
        errors++;
        $display("FAIL w_tnew got=%0d want=0", dut.w_tnew);
      end
    end
  end

  initial begin
    vec_t t;
    // lw $1 -> add $2,$1,$1 (rs==rt, tuse=1)
    vecs[0]  = v(0, 0, 1, 3, 1, TNEW_LOAD, 0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = v(1, 1, 1, 1, 2, TNEW_ALU,  1, 0, 0, 0, 0, 0, 0);
    vecs[2]  = v(1, 1, 1, 1, 2, TNEW_ALU,  0, 0, 0, 0, 0, 0, 1);
    vecs[3]  = nop(3, 3, 0, 1);
    vecs[4]  = nop(0, 0, 0, 1);
    vecs[5]  = nop(0, 0, 0, 1);
    // add $1 -> beq $1,$0 (stall, then M), second beq sees W in D and E
    vecs[6]  = v(0, 0, 1, 1, 1, TNEW_ALU, 0, 0, 0, 0, 0, 0, 1);
    vecs[7]  = v(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    vecs[8]  = v(1, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 2);
    vecs[9]  = v(1, 0, 0, 0, 0, 0, 0, 3, 0, 3, 0, 0, 2);
    vecs[10] = nop(0, 0, 0, 2);
    vecs[11] = nop(0, 0, 0, 2);
    // lw $5 -> sw $5 (tuse_rt=2): never stalls, store data from W in M
    vecs[12] = v(0, 5, 1, T_USE_NONE, 5, TNEW_LOAD, 0, 0, 0, 0, 0, 0, 2);
    vecs[13] = v(0, 5, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    vecs[14] = nop(0, 0, 0, 2);
    vecs[15] = nop(0, 0, 3, 2);
    vecs[16] = nop(0, 0, 0, 2);
    // jal -> jr $31: forwarded from E without stalling
    vecs[17] = v(0, 0, 3, 3, 31, TNEW_LINK, 0, 0, 0, 0, 0, 0, 2);
    vecs[18] = v(31, 0, 0, 3, 0, 0, 0, 1, 0, 0, 0, 0, 2);
    vecs[19] = nop(2, 0, 0, 2);
    vecs[20] = nop(0, 0, 0, 2);
    vecs[21] = nop(0, 0, 0, 2);
    // ori $0 -> add reading $0: no hazard on register 0
    vecs[22] = v(0, 0, 1, 3, 0, TNEW_ALU, 0, 0, 0, 0, 0, 0, 2);
    vecs[23] = v(0, 0, 1, 1, 3, TNEW_ALU, 0, 0, 0, 0, 0, 0, 2);
    vecs[24] = nop(0, 0, 0, 2);
    vecs[25] = nop(0, 0, 0, 2);
    vecs[26] = nop(0, 0, 0, 2);

    reset = 1'b1;
    d_rs = '0; d_rt = '0; d_tuse_rs = 2'd3; d_tuse_rt = 2'd3; d_wa = '0; d_tnew = '0;

    // Reset state
    apply(nop(0, 0, 0, 0), 1'b1, 100);
    apply(nop(0, 0, 0, 0), 1'b1, 101);

    for (int i = 0; i < NV; i++) apply(vecs[i], 1'b0, i);

    // Reset asserted during a load-use stall
    t = vecs[0]; t.cnt = 32'd2; apply(t, 1'b0, 200);
    t = vecs[1]; t.cnt = 32'd2; apply(t, 1'b0, 201);
    reset = 1'b1;
    t = vecs[1]; t.st = 1'b0; t.cnt = 32'd0; apply(t, 1'b0, 202);
    apply(nop(0, 0, 0, 0), 1'b0, 203);
    apply(nop(0, 0, 0, 0), 1'b0, 204);
    apply(nop(0, 0, 0, 0), 1'b0, 205);
    apply(nop(0, 0, 0, 0), 1'b0, 206);

    // Same lw -> add pair after reset gives the original response
    for (int i = 0; i < 5; i++) apply(vecs[i], 1'b0, 300 + i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
